// File: rtl/nand_seq_pkg.sv
// Shared opcodes, targets and enums for the NAND op sequencer.
// The opcode and target values match the command port of the flash controller.
package nand_seq_pkg;

   localparam logic [5:0] OP_SELWAY = 6'b100000;
   localparam logic [5:0] OP_SETCOL = 6'b100010;
   localparam logic [5:0] OP_SETROW = 6'b100100;
   localparam logic [5:0] OP_PROG   = 6'b000011;
   localparam logic [5:0] OP_READ   = 6'b000100;
   localparam logic [5:0] OP_ERASE  = 6'b000110;
   localparam logic [5:0] OP_STATUS = 6'b000111;

   localparam logic [4:0] TGT_PROG_10H   = 5'b00000;
   localparam logic [4:0] TGT_DEFAULT    = 5'b00101;
   localparam logic [4:0] TGT_STATUS_70H = 5'b00100;

   typedef enum logic [1:0] {
      REQ_PROG  = 2'd0,
      REQ_READ  = 2'd1,
      REQ_ERASE = 2'd2,
      REQ_RSVD  = 2'd3
   } req_op_e;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_SELWAY   = 4'd1,
      ST_SETCOL   = 4'd2,
      ST_SETROW   = 4'd3,
      ST_OPCMD    = 4'd4,
      ST_RDSTREAM = 4'd5,
      ST_STCMD    = 4'd6,
      ST_STDATA   = 4'd7,
      ST_GAP      = 4'd8,
      ST_RESP     = 4'd9
   } seq_state_e;

endpackage

// File: rtl/nand_op_sequencer.sv
// Expands one program/read/erase request into controller commands plus 70h polling; 1 cycle per step.
// Commands hold valid until ready; read data passes through with user backpressure; status beats are absorbed.
module nand_op_sequencer
   import nand_seq_pkg::*;
#(
   parameter int NumberOfWays = 2,
   parameter int MaxPolls     = 1024,
   parameter int PollGap      = 16
) (
   input  logic        iSystemClock,
   input  logic        iReset,
   input  logic [1:0]  iReqOp,
   input  logic [7:0]  iReqWay,
   input  logic [15:0] iReqCol,
   input  logic [23:0] iReqRow,
   input  logic [15:0] iReqLength,
   input  logic        iReqValid,
   output logic        oReqReady,
   output logic        oRspValid,
   input  logic        iRspReady,
   output logic [7:0]  oRspStatus,
   output logic        oRspFail,
   output logic        oRspTimeout,
   output logic [5:0]  oNfcOpcode,
   output logic [4:0]  oNfcTargetID,
   output logic [4:0]  oNfcSourceID,
   output logic [31:0] oNfcAddress,
   output logic [15:0] oNfcLength,
   output logic        oNfcCMDValid,
   input  logic        iNfcCMDReady,
   input  logic [15:0] iNfcReadData,
   input  logic        iNfcReadLast,
   input  logic        iNfcReadValid,
   output logic        oNfcReadReady,
   output logic [15:0] oUserReadData,
   output logic        oUserReadLast,
   output logic        oUserReadValid,
   input  logic        iUserReadReady
);

   localparam logic [15:0] MaxPolls16 = 16'(MaxPolls);
   localparam logic [15:0] GapLast    = (PollGap > 0) ? 16'(PollGap - 1) : 16'd0;

   seq_state_e  r_state;
   req_op_e     r_op;
   logic [7:0]  r_way;
   logic [15:0] r_col;
   logic [23:0] r_row;
   logic [15:0] r_len;
   logic [15:0] r_polls;
   logic [15:0] r_gap_cnt;
   logic [7:0]  r_status;
   logic        r_fail;
   logic        r_timeout;

   logic        w_way_bad;
   logic        w_rd_hs;
   logic [7:0]  w_beat_status;

   assign w_way_bad     = ({24'd0, iReqWay} >= $unsigned(NumberOfWays));
   assign w_rd_hs       = iNfcReadValid & oNfcReadReady;
   assign w_beat_status = iNfcReadData[7:0];

   assign oReqReady   = (r_state == ST_IDLE);
   assign oRspValid   = (r_state == ST_RESP);
   assign oRspStatus  = (r_state == ST_RESP) ? r_status : 8'd0;
   assign oRspFail    = (r_state == ST_RESP) & r_fail;
   assign oRspTimeout = (r_state == ST_RESP) & r_timeout;

   // Command fields decode purely from state and latched request, so they cannot move while stalled.
   always_comb begin
      oNfcCMDValid = 1'b0;
      oNfcOpcode   = 6'd0;
      oNfcTargetID = 5'd0;
      oNfcSourceID = 5'd0;
      oNfcAddress  = 32'd0;
      oNfcLength   = 16'd0;
      case (r_state)
         ST_SELWAY: begin
            oNfcCMDValid = 1'b1;
            oNfcOpcode   = OP_SELWAY;
            oNfcAddress  = {24'd0, r_way};
         end
         ST_SETCOL: begin
            oNfcCMDValid = 1'b1;
            oNfcOpcode   = OP_SETCOL;
            oNfcAddress  = {16'd0, r_col};
         end
         ST_SETROW: begin
            oNfcCMDValid = 1'b1;
            oNfcOpcode   = OP_SETROW;
            oNfcAddress  = {8'd0, r_row};
         end
         ST_OPCMD: begin
            oNfcCMDValid = 1'b1;
            case (r_op)
               REQ_PROG: begin
                  oNfcOpcode   = OP_PROG;
                  oNfcTargetID = TGT_PROG_10H;
                  oNfcLength   = r_len;
               end
               REQ_READ: begin
                  oNfcOpcode   = OP_READ;
                  oNfcTargetID = TGT_DEFAULT;
                  oNfcLength   = r_len;
               end
               default: begin
                  oNfcOpcode   = OP_ERASE;
                  oNfcTargetID = TGT_DEFAULT;
               end
            endcase
         end
         ST_STCMD: begin
            oNfcCMDValid = 1'b1;
            oNfcOpcode   = OP_STATUS;
            oNfcTargetID = TGT_STATUS_70H;
            oNfcLength   = 16'd8;
         end
         default: ;
      endcase
   end

   always_comb begin
      oNfcReadReady  = 1'b0;
      oUserReadValid = 1'b0;
      oUserReadData  = 16'd0;
      oUserReadLast  = 1'b0;
      if (r_state == ST_RDSTREAM) begin
         oNfcReadReady  = iUserReadReady;
         oUserReadValid = iNfcReadValid;
         oUserReadData  = iNfcReadData;
         oUserReadLast  = iNfcReadLast;
      end else if (r_state == ST_STDATA) begin
         oNfcReadReady = 1'b1;
      end
   end

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         r_state   <= ST_IDLE;
         r_op      <= REQ_PROG;
         r_way     <= 8'd0;
         r_col     <= 16'd0;
         r_row     <= 24'd0;
         r_len     <= 16'd0;
         r_polls   <= 16'd0;
         r_gap_cnt <= 16'd0;
         r_status  <= 8'd0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (iReqValid) begin
                  r_op      <= (iReqOp == REQ_RSVD) ? REQ_ERASE : req_op_e'(iReqOp);
                  r_way     <= iReqWay;
                  r_col     <= iReqCol;
                  r_row     <= iReqRow;
                  r_len     <= iReqLength;
                  r_polls   <= 16'd0;
                  r_status  <= 8'd0;
                  r_fail    <= w_way_bad;
                  r_timeout <= 1'b0;
                  r_state   <= w_way_bad ? ST_RESP : ST_SELWAY;
               end
            end
            ST_SELWAY: if (iNfcCMDReady) r_state <= ST_SETCOL;
            ST_SETCOL: if (iNfcCMDReady) r_state <= ST_SETROW;
            ST_SETROW: if (iNfcCMDReady) r_state <= ST_OPCMD;
            ST_OPCMD: begin
               if (iNfcCMDReady) r_state <= (r_op == REQ_READ) ? ST_RDSTREAM : ST_STCMD;
            end
            ST_RDSTREAM: begin
               if (w_rd_hs && iNfcReadLast) r_state <= ST_RESP;
            end
            ST_STCMD: begin
               if (iNfcCMDReady) begin
                  r_polls <= (r_polls == 16'hFFFF) ? r_polls : r_polls + 16'd1;
                  r_state <= ST_STDATA;
               end
            end
            ST_STDATA: begin
               // Decide on the incoming byte: the last beat of the status stream wins.
               if (w_rd_hs) begin
                  r_status <= w_beat_status;
                  if (iNfcReadLast) begin
                     if (w_beat_status[5]) begin
                        r_fail  <= w_beat_status[0];
                        r_state <= ST_RESP;
                     end else if (r_polls == MaxPolls16) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_RESP;
                     end else begin
                        r_gap_cnt <= 16'd0;
                        r_state   <= ST_GAP;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (r_gap_cnt >= GapLast) r_state <= ST_STCMD;
               else r_gap_cnt <= r_gap_cnt + 16'd1;
            end
            ST_RESP: if (iRspReady) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboarded bench: stimulus queues expected commands, beats and responses; monitors pop and compare.
module tb_nand_op_sequencer;
   import nand_seq_pkg::*;

   localparam int NW = 2;
   localparam int MP = 4;
   localparam int PG = 6;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  tgt;
      logic [4:0]  src;
      logic [31:0] addr;
      logic [15:0] len;
   } cmd_t;
   typedef struct packed {
      logic [7:0] st;
      logic       fail;
      logic       tmo;
   } rsp_t;
   typedef struct packed {
      logic [15:0] d;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        iReset;
   logic [1:0]  iReqOp;
   logic [7:0]  iReqWay;
   logic [15:0] iReqCol;
   logic [23:0] iReqRow;
   logic [15:0] iReqLength;
   logic        iReqValid;
   logic        oReqReady;
   logic        oRspValid;
   logic        iRspReady;
   logic [7:0]  oRspStatus;
   logic        oRspFail;
   logic        oRspTimeout;
   logic [5:0]  oNfcOpcode;
   logic [4:0]  oNfcTargetID;
   logic [4:0]  oNfcSourceID;
   logic [31:0] oNfcAddress;
   logic [15:0] oNfcLength;
   logic        oNfcCMDValid;
   logic        iNfcCMDReady;
   logic [15:0] iNfcReadData;
   logic        iNfcReadLast;
   logic        iNfcReadValid;
   logic        oNfcReadReady;
   logic [15:0] oUserReadData;
   logic        oUserReadLast;
   logic        oUserReadValid;
   logic        iUserReadReady;

   nand_op_sequencer #(.NumberOfWays(NW), .MaxPolls(MP), .PollGap(PG)) dut (
      .iSystemClock(clk), .iReset(iReset),
      .iReqOp(iReqOp), .iReqWay(iReqWay), .iReqCol(iReqCol), .iReqRow(iReqRow),
      .iReqLength(iReqLength), .iReqValid(iReqValid), .oReqReady(oReqReady),
      .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspStatus(oRspStatus),
      .oRspFail(oRspFail), .oRspTimeout(oRspTimeout),
      .oNfcOpcode(oNfcOpcode), .oNfcTargetID(oNfcTargetID), .oNfcSourceID(oNfcSourceID),
      .oNfcAddress(oNfcAddress), .oNfcLength(oNfcLength),
      .oNfcCMDValid(oNfcCMDValid), .iNfcCMDReady(iNfcCMDReady),
      .iNfcReadData(iNfcReadData), .iNfcReadLast(iNfcReadLast),
      .iNfcReadValid(iNfcReadValid), .oNfcReadReady(oNfcReadReady),
      .oUserReadData(oUserReadData), .oUserReadLast(oUserReadLast),
      .oUserReadValid(oUserReadValid), .iUserReadReady(iUserReadReady)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int cmd_stall = 0;
   int rsp_seen = 0;
   int last_beats_done = 0;
   int last_stat_cyc = -1;
   logic toggle_en = 1'b0;

   cmd_t        exp_cmd[$];
   rsp_t        exp_rsp[$];
   beat_t       exp_user[$];
   beat_t       nfc_beats[$];
   logic [15:0] status_replies[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got an unexpected event, expected none", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [5:0] op, input logic [4:0] tgt,
                           input logic [31:0] addr, input logic [15:0] len);
      exp_cmd.push_back({op, tgt, 5'd0, addr, len});
   endtask

   task automatic push_setup(input logic [7:0] way, input logic [15:0] col, input logic [23:0] row);
      push_cmd(OP_SELWAY, 5'd0, {24'd0, way}, 16'd0);
      push_cmd(OP_SETCOL, 5'd0, {16'd0, col}, 16'd0);
      push_cmd(OP_SETROW, 5'd0, {8'd0, row}, 16'd0);
   endtask

   task automatic push_status(input int n);
      for (int i = 0; i < n; i++) push_cmd(OP_STATUS, TGT_STATUS_70H, 32'd0, 16'd8);
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] way, input logic [15:0] col,
                        input logic [23:0] row, input logic [15:0] len, output int seen0);
      int t = 0;
      seen0 = rsp_seen;
      last_stat_cyc = -1;
      while (!oReqReady && t < 200) begin step(); t++; end
      if (!oReqReady) fail_now("req_ready_wait_expired");
      iReqOp = op; iReqWay = way; iReqCol = col; iReqRow = row; iReqLength = len;
      iReqValid = 1'b1;
      step();
      iReqValid = 1'b0;
      chk("req_ready_low_after_accept", 64'(oReqReady), 64'd0);
      if (way < NW) chk("cmd_valid_latency", 64'(oNfcCMDValid), 64'd1);
      else chk("bad_way_rsp_latency", 64'(oRspValid), 64'd1);
   endtask

   task automatic await_rsp(input int seen0);
      int t = 0;
      while (rsp_seen == seen0 && t < 3000) begin step(); t++; end
      if (rsp_seen == seen0) fail_now("rsp_wait_expired");
      step(); step();
      chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
      exp_cmd.delete();
   endtask

   // Controller model: accepts commands, answers status/read commands with beats.
   initial begin
      cmd_t        c, prev;
      logic        hs, rhs, stalled, rst_now, rst_prev;
      logic [15:0] r;
      beat_t       b;
      stalled = 1'b0; rst_prev = 1'b1; prev = '0;
      iNfcCMDReady = 1'b0; iNfcReadValid = 1'b0; iNfcReadData = 16'd0; iNfcReadLast = 1'b0;
      forever begin
         @(negedge clk);
         c = {oNfcOpcode, oNfcTargetID, oNfcSourceID, oNfcAddress, oNfcLength};
         rst_now = iReset;
         if (stalled && !rst_prev && !rst_now) begin
            chk("cmd_valid_held", 64'(oNfcCMDValid), 64'd1);
            chk("cmd_fields_stable", 64'(c), 64'(prev));
         end
         hs = oNfcCMDValid && iNfcCMDReady && !rst_now;
         rhs = iNfcReadValid && oNfcReadReady && !rst_now;
         stalled = oNfcCMDValid && !iNfcCMDReady;
         prev = c;
         rst_prev = rst_now;
         if (hs) begin
            if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
            else chk("cmd", 64'(c), 64'(exp_cmd.pop_front()));
         end
         @(posedge clk);
         #1;
         if (rst_now) begin
            nfc_beats.delete();
         end else begin
            if (hs && c.op == OP_STATUS) begin
               if (last_stat_cyc >= 0) chk("poll_gap_ok", 64'((cyc - last_stat_cyc) >= PG), 64'd1);
               last_stat_cyc = cyc;
               r = (status_replies.size() > 0) ? status_replies.pop_front() : 16'h0000;
               if (r[15:8] != 8'd0) nfc_beats.push_back({8'hAA, r[15:8], 1'b0});
               nfc_beats.push_back({8'hA5, r[7:0], 1'b1});
            end
            if (hs && c.op == OP_READ) begin
               nfc_beats.push_back({16'h0102, 1'b0});
               nfc_beats.push_back({16'h0304, 1'b0});
               nfc_beats.push_back({16'h0506, 1'b0});
               nfc_beats.push_back({16'h0708, 1'b1});
            end
            if (rhs && nfc_beats.size() > 0) begin
               b = nfc_beats.pop_front();
               if (b.last) last_beats_done++;
            end
         end
         if (nfc_beats.size() > 0) begin
            b = nfc_beats[0];
            iNfcReadValid = 1'b1; iNfcReadData = b.d; iNfcReadLast = b.last;
         end else begin
            iNfcReadValid = 1'b0; iNfcReadData = 16'd0; iNfcReadLast = 1'b0;
         end
         iNfcCMDReady = (cmd_stall == 0);
         if (cmd_stall > 0 && oNfcCMDValid) cmd_stall--;
      end
   end

   // Response monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (oRspValid && iRspReady && !iReset) begin
            chk("req_ready_during_rsp", 64'(oReqReady), 64'd0);
            if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
            else chk("rsp", 64'({oRspStatus, oRspFail, oRspTimeout}), 64'(exp_rsp.pop_front()));
            rsp_seen++;
         end
      end
   end

   // User read-stream monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (oUserReadValid && iUserReadReady && !iReset) begin
            if (exp_user.size() == 0) fail_now("unexpected_user_beat");
            else chk("user_beat", 64'({oUserReadData, oUserReadLast}), 64'(exp_user.pop_front()));
         end
      end
   end

   initial begin
      iUserReadReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         iUserReadReady = toggle_en ? ((cyc % 3) != 0) : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
      $fatal(1);
   end

   initial begin
      int s0, t;
      iReset = 1'b1; iReqValid = 1'b0; iReqOp = 2'd0; iReqWay = 8'd0; iReqCol = 16'd0;
      iReqRow = 24'd0; iReqLength = 16'd0; iRspReady = 1'b1;
      repeat (3) step();
      chk("rst_req_ready", 64'(oReqReady), 64'd1);
      chk("rst_rsp_valid", 64'(oRspValid), 64'd0);
      chk("rst_cmd_valid", 64'(oNfcCMDValid), 64'd0);
      chk("rst_cmd_fields", 64'({oNfcOpcode, oNfcTargetID, oNfcSourceID, oNfcAddress, oNfcLength}), 64'd0);
      chk("rst_rsp_fields", 64'({oRspStatus, oRspFail, oRspTimeout}), 64'd0);
      chk("rst_read_path", 64'({oNfcReadReady, oUserReadValid, oUserReadData, oUserReadLast}), 64'd0);
      iReset = 1'b0;
      step();

      // Program success after two busy polls.
      status_replies = '{16'h0000, 16'h0000, 16'h0060};
      push_setup(8'd1, 16'h0010, 24'h000003);
      push_cmd(OP_PROG, TGT_PROG_10H, 32'd0, 16'd8);
      push_status(3);
      exp_rsp.push_back({8'h60, 1'b0, 1'b0});
      issue(2'd0, 8'd1, 16'h0010, 24'h000003, 16'd8, s0);
      await_rsp(s0);

      // Program fail, two-beat status (last wins), response held under backpressure.
      status_replies = '{16'hE061};
      push_setup(8'd0, 16'h0200, 24'h00ABCD);
      push_cmd(OP_PROG, TGT_PROG_10H, 32'd0, 16'd16);
      push_status(1);
      exp_rsp.push_back({8'h61, 1'b1, 1'b0});
      iRspReady = 1'b0;
      issue(2'd0, 8'd0, 16'h0200, 24'h00ABCD, 16'd16, s0);
      t = 0;
      while (!oRspValid && t < 500) begin step(); t++; end
      if (!oRspValid) fail_now("rsp_valid_wait_expired");
      repeat (3) begin
         step();
         chk("rsp_held", 64'({oRspValid, oRspStatus, oRspFail, oRspTimeout}), 64'({1'b1, 8'h61, 1'b1, 1'b0}));
      end
      iRspReady = 1'b1;
      await_rsp(s0);

      // Timeout: die never ready, exactly MP polls.
      push_setup(8'd1, 16'h0000, 24'h000040);
      push_cmd(OP_ERASE, TGT_DEFAULT, 32'd0, 16'd0);
      push_status(MP);
      exp_rsp.push_back({8'h00, 1'b0, 1'b1});
      issue(2'd2, 8'd1, 16'h0000, 24'h000040, 16'd0, s0);
      await_rsp(s0);

      // Read pass-through with a toggling user ready.
      toggle_en = 1'b1;
      push_setup(8'd0, 16'h0004, 24'h000102);
      push_cmd(OP_READ, TGT_DEFAULT, 32'd0, 16'd8);
      exp_user.push_back({16'h0102, 1'b0});
      exp_user.push_back({16'h0304, 1'b0});
      exp_user.push_back({16'h0506, 1'b0});
      exp_user.push_back({16'h0708, 1'b1});
      exp_rsp.push_back({8'h00, 1'b0, 1'b0});
      issue(2'd1, 8'd0, 16'h0004, 24'h000102, 16'd8, s0);
      await_rsp(s0);
      toggle_en = 1'b0;
      chk("user_queue_drained", 64'(exp_user.size()), 64'd0);

      // Erase with the controller stalling the command port.
      cmd_stall = 5;
      status_replies = '{16'h0060};
      push_setup(8'd1, 16'h0000, 24'h000777);
      push_cmd(OP_ERASE, TGT_DEFAULT, 32'd0, 16'd0);
      push_status(1);
      exp_rsp.push_back({8'h60, 1'b0, 1'b0});
      issue(2'd2, 8'd1, 16'h0000, 24'h000777, 16'd0, s0);
      await_rsp(s0);

      // Reserved op behaves as erase.
      status_replies = '{16'h00E0};
      push_setup(8'd0, 16'h0001, 24'h000900);
      push_cmd(OP_ERASE, TGT_DEFAULT, 32'd0, 16'd0);
      push_status(1);
      exp_rsp.push_back({8'hE0, 1'b0, 1'b0});
      issue(2'd3, 8'd0, 16'h0001, 24'h000900, 16'd32, s0);
      await_rsp(s0);

      // Bad ways: immediate fail, no commands.
      exp_rsp.push_back({8'h00, 1'b1, 1'b0});
      issue(2'd0, 8'd2, 16'h0000, 24'h000000, 16'd8, s0);
      await_rsp(s0);
      exp_rsp.push_back({8'h00, 1'b1, 1'b0});
      issue(2'd1, 8'hFF, 16'h0000, 24'h000000, 16'd8, s0);
      await_rsp(s0);

      // Reset while waiting in the poll gap.
      push_setup(8'd0, 16'h0000, 24'h000005);
      push_cmd(OP_PROG, TGT_PROG_10H, 32'd0, 16'd4);
      push_status(1);
      t = last_beats_done;
      issue(2'd0, 8'd0, 16'h0000, 24'h000005, 16'd4, s0);
      s0 = 0;
      while (last_beats_done == t && s0 < 500) begin step(); s0++; end
      if (last_beats_done == t) fail_now("status_beat_wait_expired");
      step();
      iReset = 1'b1;
      step();
      iReset = 1'b0;
      chk("midrst_cmd_valid", 64'(oNfcCMDValid), 64'd0);
      chk("midrst_rsp_valid", 64'(oRspValid), 64'd0);
      chk("midrst_req_ready", 64'(oReqReady), 64'd1);
      repeat (PG + 4) step();
      chk("midrst_cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
      exp_cmd.delete();

      // Ready on the final allowed poll beats the timeout; poll count restarts per request.
      status_replies = '{16'h0000, 16'h0000, 16'h0000, 16'h0060};
      push_setup(8'd1, 16'h0123, 24'h00FEDC);
      push_cmd(OP_PROG, TGT_PROG_10H, 32'd0, 16'd2);
      push_status(MP);
      exp_rsp.push_back({8'h60, 1'b0, 1'b0});
      issue(2'd0, 8'd1, 16'h0123, 24'h00FEDC, 16'd2, s0);
      await_rsp(s0);

      repeat (3) step();
      chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nand_op_sequencer.md
# nand_op_sequencer

Command sequencer that sits directly upstream of `NandFlashController_Top` on its command port. It turns one high-level request (program page, read page, erase block) into the primitive command sequence: select way, set column, set row, operation, then repeated 70h read-status polls until the die is ready. It returns one response carrying the final status byte, a fail flag and a timeout flag. The write-data stream bypasses this block. The read-data stream passes through it, except for status beats, which the block consumes.

## Interface
Parameters:
- `NumberOfWays`, default 2: number of ways; sizes the way-select check.
- `MaxPolls`, default 1024: maximum status polls before timeout.
- `PollGap`, default 16: idle cycles between a status beat and the next poll command.

Ports:
- `iSystemClock` in 1: the single clock.
- `iReset` in 1: reset, synchronous and active-high.
- `iReqOp` in 2: request type; 0 = program, 1 = read, 2 = erase, 3 = reserved (treated as erase).
- `iReqWay` in 8, `iReqCol` in 16, `iReqRow` in 24, `iReqLength` in 16: way index, column address, row address, byte length.
- `iReqValid` in 1 / `oReqReady` out 1: request handshake.
- `oRspValid` out 1 / `iRspReady` in 1: response handshake.
- `oRspStatus` out 8: last status byte.
- `oRspFail` out 1: program/erase failure.
- `oRspTimeout` out 1: poll limit reached.
- `oNfcOpcode` out 6, `oNfcTargetID` out 5, `oNfcSourceID` out 5, `oNfcAddress` out 32, `oNfcLength` out 16: controller command fields.
- `oNfcCMDValid` out 1 / `iNfcCMDReady` in 1: controller command handshake.
- `iNfcReadData` in 16, `iNfcReadLast` in 1, `iNfcReadValid` in 1 / `oNfcReadReady` out 1: read stream from the controller.
- `oUserReadData` out 16, `oUserReadLast` out 1, `oUserReadValid` out 1 / `iUserReadReady` in 1: read stream to the user.

## Operation
FSM states: IDLE, SELWAY, SETCOL, SETROW, OPCMD, RDSTREAM, STCMD, STDATA, GAP, RESP.

- **IDLE**
  - `oReqReady` = 1.
  - On `iReqValid`: register all request fields, clear the poll counter, go to SELWAY.
- **Command states.** Each drives one command and holds `oNfcCMDValid` = 1 with stable fields until `iNfcCMDReady`, then advances. `oNfcSourceID` = 0 always.
  - SELWAY: opcode 6'b100000, address {24'd0, way}.
  - SETCOL: opcode 6'b100010, address {16'd0, col}.
  - SETROW: opcode 6'b100100, address {8'd0, row}.
  - OPCMD:
    - program: opcode 6'b000011, target 5'b00000, length = `iReqLength`.
    - read: opcode 6'b000100, target 5'b00101.
    - erase: opcode 6'b000110, target 5'b00101.
  - After OPCMD, program and erase go to STCMD; read goes to RDSTREAM.
- **RDSTREAM**
  - Read stream passes through combinationally.
  - Leave for RESP on the handshake of the beat with `iNfcReadLast` = 1.
  - Read responses report status 0, fail 0, timeout 0.
- **STCMD**
  - Command: opcode 6'b000111, target 5'b00100, length 8.
  - Increment the poll counter on acceptance, then go to STDATA.
- **STDATA**
  - `oNfcReadReady` = 1 and `oUserReadValid` = 0; status beats are never forwarded to the user.
  - Each handshaked beat captures `iNfcReadData[7:0]` into the status register.
  - On the beat with `iNfcReadLast` = 1:
    - if status bit 5 (ARDY) = 1 → RESP with fail = status bit 0;
    - else if the poll counter = `MaxPolls` → RESP with timeout = 1;
    - else → GAP.
- **GAP**: count `PollGap` cycles, then go to STCMD.
- **RESP**
  - `oRspValid` = 1; fields stay stable until `iRspReady`, then go to IDLE.
- **Read-path mux, outside RDSTREAM and STDATA**: `oNfcReadReady` = 0 and `oUserReadValid` = 0.
- **Way check**: `iReqWay` ≥ `NumberOfWays` skips straight to RESP with fail = 1 and issues no commands.

## Timing
- Reset values: state IDLE, `oReqReady` 1, `oRspValid` 0, `oNfcCMDValid` 0, every data/field output 0, poll counter 0.
- Reset mid-operation returns to IDLE on the next edge. No response is produced for the aborted request; the controller shares `iReset`.
- Latencies:
  - request accept to `oNfcCMDValid` rising: 1 cycle;
  - command accept to next command's valid: 1 cycle;
  - last status beat to RESP, or to GAP start: 1 cycle.
- Command handshake: fields may change only in the cycle after acceptance. Valid is never dropped before ready.
- `oReqReady` is 0 from the accept cycle until the RESP handshake completes; a request and a response are never in the same cycle.
- The poll counter is 16 bits, saturating; it never wraps.
- A status stream of more than one beat: the last beat's byte wins.

## Structure
- Shared package `nand_seq_pkg`:
  - opcode constants: OP_SELWAY, OP_SETCOL, OP_SETROW, OP_PROG, OP_READ, OP_ERASE, OP_STATUS;
  - target constants: TGT_PROG_10H = 5'b00000, TGT_DEFAULT = 5'b00101, TGT_STATUS_70H = 5'b00100;
  - request-type enum and FSM state enum.
- Single module, no sub-module; read-path mux is inline combinational logic.

## Test plan
- **Program success**: way 1, row 0x000003, length 8; status replies 0x00 twice, then 0x60 → command order 0x20, 0x22, 0x24, 0x03, then 3× 0x07; response status 0x60, fail 0, timeout 0.
- **Program fail**: final status 0x61 → `oRspFail` = 1, `oRspStatus` 0x61.
- **Timeout**: `MaxPolls` = 4, status always 0x00 → exactly 4 status commands; `oRspTimeout` = 1; consecutive polls separated by ≥ `PollGap` cycles.
- **Read**: 4 beats 0x0102, 0x0304, 0x0506, 0x0708, with `iUserReadReady` toggling → user sees the 4 beats in order with last on 0x0708, no stalled beat is lost, no status command is issued.
- **Back-pressure and bad way**: `iNfcCMDReady` low for 5 cycles → fields stable throughout. Way 2 with `NumberOfWays` = 2 → immediate response with fail = 1 and zero commands.
- **Reset mid-poll**: `iReset` asserted during GAP → next cycle IDLE, `oNfcCMDValid` 0, `oRspValid` 0, `oReqReady` 1.
